// File: rtl/cascade_stage_sequencer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : cascade_stage_sequencer_if
// Purpose  : Window control, parameter-memory read port, accumulator parameter
//            feed and stage-sum return of the cascade stage sequencer.
//            'master' is the sequencer's view; 'slave' is the surrounding logic.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface cascade_stage_sequencer_if #(
   parameter int ADDR_W = 16
);
   // window control
   logic              start_i;
   logic              busy_o;
   // parameter memory
   logic              mem_rd_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [31:0]       mem_rdata_i;
   logic              mem_rdata_val_i;
   // stage-sum accumulator
   logic              new_stage_o;
   logic [31:0]       thresholds_o;
   logic [1:0]        thresholds_type_o;
   logic              thresholds_val_o;
   logic [31:0]       stage_sum_i;
   logic              stage_sum_val_i;
   // decision
   logic              result_val_o;
   logic              result_pass_o;
   logic [7:0]        result_stage_o;

   modport master (
      input  start_i, mem_rdata_i, mem_rdata_val_i, stage_sum_i, stage_sum_val_i,
      output busy_o, mem_rd_o, mem_addr_o, new_stage_o, thresholds_o,
             thresholds_type_o, thresholds_val_o, result_val_o, result_pass_o,
             result_stage_o
   );

   modport slave (
      output start_i, mem_rdata_i, mem_rdata_val_i, stage_sum_i, stage_sum_val_i,
      input  busy_o, mem_rd_o, mem_addr_o, new_stage_o, thresholds_o,
             thresholds_type_o, thresholds_val_o, result_val_o, result_pass_o,
             result_stage_o
   );
endinterface
`default_nettype wire

// File: rtl/cascade_stage_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : cascade_stage_sequencer
// Purpose  : Walks the cascade parameter memory stage by stage, feeds alpha and
//            node-threshold words to the stage-sum accumulator one feature at a
//            time, compares each final stage sum against the stage threshold and
//            reports pass/reject for the current detection window.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module cascade_stage_sequencer #(
   parameter int STAGE_CNT = 22,
   parameter int ADDR_W    = 16,
   parameter int FEAT_W    = 12,
   parameter int BASE_ADDR = 0
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   cascade_stage_sequencer_if.master bus
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      RD_N     = 4'd1,
      RD_TH    = 4'd2,
      RD_LEFT  = 4'd3,
      RD_RIGHT = 4'd4,
      RD_NODE  = 4'd5,
      WAIT_SUM = 4'd6,
      DECIDE   = 4'd7,
      DONE     = 4'd8
   } state_t;

   localparam logic [1:0] TYPE_NODE  = 2'b00;
   localparam logic [1:0] TYPE_LEFT  = 2'b01;
   localparam logic [1:0] TYPE_RIGHT = 2'b10;

   state_t            state;
   state_t            state_nxt;

   logic              outstanding;   // one read in flight
   logic [ADDR_W-1:0] ptr;
   logic [FEAT_W-1:0] n_feat;
   logic [FEAT_W-1:0] feat_cnt;
   logic [FEAT_W-1:0] feat_nxt;
   logic [31:0]       stage_th;
   logic [31:0]       stage_sum;
   logic [7:0]        stage_idx;
   logic [31:0]       thr_word;
   logic [1:0]        thr_type;
   logic              thr_val;
   logic              res_pass;
   logic [7:0]        res_stage;

   logic              rd_state;
   logic              rd_req;
   logic              accept;
   logic              sum_take;
   logic              start_ok;
   logic              last_feat;
   logic              last_stage;
   logic              pass_stage;

   // IEEE-754 single a >= b using sign-magnitude ordering; both zeros compare equal
   function automatic logic fp_ge(input logic [31:0] a, input logic [31:0] b);
      logic a_zero;
      logic b_zero;
      a_zero = (a[30:0] == 31'd0);
      b_zero = (b[30:0] == 31'd0);
      if (a_zero && b_zero)
         return 1'b1;
      if (a[31] != b[31])
         return b[31];
      if (!a[31])
         return (a[30:0] >= b[30:0]);
      return (a[30:0] <= b[30:0]);
   endfunction

   assign rd_state   = (state == RD_N) || (state == RD_TH) || (state == RD_LEFT) ||
                       (state == RD_RIGHT) || (state == RD_NODE);
   // a new read is requested on the first cycle of every read state only
   assign rd_req     = rd_state && !outstanding;
   // data returning while nothing is outstanding is dropped here
   assign accept     = rd_state && outstanding && bus.mem_rdata_val_i;
   assign sum_take   = (state == WAIT_SUM) && bus.stage_sum_val_i;
   assign start_ok   = (state == IDLE) && bus.start_i;
   assign feat_nxt   = feat_cnt + FEAT_W'(1);
   assign last_feat  = (feat_nxt == n_feat);
   assign last_stage = (stage_idx == 8'(STAGE_CNT - 1));
   assign pass_stage = fp_ge(stage_sum, stage_th);

   assign bus.thresholds_o      = thr_word;
   assign bus.thresholds_type_o = thr_type;
   assign bus.thresholds_val_o  = thr_val;
   assign bus.result_pass_o     = res_pass;
   assign bus.result_stage_o    = res_stage;

   // state register
   always_ff @(posedge clk_i) begin
      if (rst_i)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // next-state and combinational handshake outputs
   always_comb begin
      state_nxt            = state;
      bus.busy_o           = 1'b0;
      bus.mem_rd_o         = 1'b0;
      bus.mem_addr_o       = '0;
      bus.new_stage_o      = 1'b0;
      bus.result_val_o     = 1'b0;

      if (rd_req) begin
         bus.mem_rd_o   = 1'b1;
         bus.mem_addr_o = ptr;
      end
      bus.busy_o = (state != IDLE) && (state != DONE);

      case (state)
         IDLE: begin
            if (bus.start_i)
               state_nxt = RD_N;
         end
         RD_N: begin
            if (accept) begin
               bus.new_stage_o = 1'b1;
               state_nxt       = RD_TH;
            end
         end
         RD_TH: begin
            if (accept)
               state_nxt = (n_feat == '0) ? DECIDE : RD_LEFT;
         end
         RD_LEFT: begin
            if (accept)
               state_nxt = RD_RIGHT;
         end
         RD_RIGHT: begin
            if (accept)
               state_nxt = RD_NODE;
         end
         RD_NODE: begin
            if (accept)
               state_nxt = WAIT_SUM;
         end
         WAIT_SUM: begin
            // next feature's alphas wait for this feature's sum
            if (sum_take)
               state_nxt = last_feat ? DECIDE : RD_LEFT;
         end
         DECIDE: begin
            if (!pass_stage || last_stage)
               state_nxt = DONE;
            else
               state_nxt = RD_N;
         end
         DONE: begin
            bus.result_val_o = 1'b1;
            state_nxt        = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // read tracking and parameter address pointer
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         outstanding <= 1'b0;
         ptr         <= ADDR_W'(BASE_ADDR);
      end else begin
         if (rd_req)
            outstanding <= 1'b1;
         else if (accept)
            outstanding <= 1'b0;

         if (start_ok)
            ptr <= ADDR_W'(BASE_ADDR);
         else if (accept)
            ptr <= ptr + ADDR_W'(1);
      end
   end

   // stage header, feature counter and stage sum capture
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         n_feat    <= '0;
         feat_cnt  <= '0;
         stage_th  <= '0;
         stage_sum <= '0;
         stage_idx <= '0;
      end else begin
         if (start_ok)
            stage_idx <= '0;
         if ((state == RD_N) && accept) begin
            n_feat   <= bus.mem_rdata_i[FEAT_W-1:0];
            feat_cnt <= '0;
         end
         if ((state == RD_TH) && accept) begin
            stage_th <= bus.mem_rdata_i;
            // an empty stage is judged on a sum of +0.0
            if (n_feat == '0)
               stage_sum <= '0;
         end
         if (sum_take) begin
            stage_sum <= bus.stage_sum_i;
            feat_cnt  <= feat_nxt;
         end
         if ((state == DECIDE) && pass_stage && !last_stage)
            stage_idx <= stage_idx + 8'd1;
      end
   end

   // parameter word presented to the accumulator one cycle after its return
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         thr_word <= '0;
         thr_type <= '0;
         thr_val  <= 1'b0;
      end else begin
         thr_val <= 1'b0;
         if (accept && ((state == RD_LEFT) || (state == RD_RIGHT) || (state == RD_NODE))) begin
            thr_word <= bus.mem_rdata_i;
            thr_val  <= 1'b1;
            case (state)
               RD_LEFT:  thr_type <= TYPE_LEFT;
               RD_RIGHT: thr_type <= TYPE_RIGHT;
               default:  thr_type <= TYPE_NODE;
            endcase
         end
      end
   end

   // decision registers, held from DONE until the next accepted start
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         res_pass  <= 1'b0;
         res_stage <= '0;
      end else begin
         if (start_ok) begin
            res_pass  <= 1'b0;
            res_stage <= '0;
         end else if (state == DECIDE) begin
            if (!pass_stage) begin
               res_pass  <= 1'b0;
               res_stage <= stage_idx;
            end else if (last_stage) begin
               res_pass  <= 1'b1;
               res_stage <= stage_idx;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/cascade_stage_sequencer.md
Name: cascade_stage_sequencer

Overview:
- Drives the stage-sum accumulator's parameter interface: reads classifier parameters from the cascade parameter memory and emits alpha and node-threshold words with their type codes.
- Pulses new_stage at each stage boundary, consumes the returned stage sums and compares each final stage sum against the stage threshold.
- Reports pass/reject for the current detection window.
- Sits between the parameter ROM and the stage-sum block, one instance per window pipeline.

Parameters:
STAGE_CNT, 22, number of stages in the cascade
ADDR_W, 16, parameter memory address width
FEAT_W, 12, width of per-stage feature counter
BASE_ADDR, 0, memory address of stage 0 header

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
start_i  input  1  one-cycle pulse: evaluate cascade for current window
busy_o  output  1  high from accepted start_i until result_val_o
mem_rd_o  output  1  one-cycle read request
mem_addr_o  output  ADDR_W  read address, valid with mem_rd_o
mem_rdata_i  input  32  read data
mem_rdata_val_i  input  1  read data valid (any latency >=1 cycle)
new_stage_o  output  1  one-cycle pulse: clear stage accumulator
thresholds_o  output  32  fp32 parameter word
thresholds_type_o  output  2  00 node threshold, 01 left alpha, 10 right alpha
thresholds_val_o  output  1  one-cycle qualifier for thresholds_o/type
stage_sum_i  input  32  fp32 running stage sum
stage_sum_val_i  input  1  stage sum valid (one per feature)
result_val_o  output  1  one-cycle pulse: decision ready
result_pass_o  output  1  1 = window passed all stages
result_stage_o  output  8  index of rejecting stage; STAGE_CNT-1 on pass

Behaviour:
- Reset: all outputs 0, FSM to IDLE, address pointer = BASE_ADDR, counters 0.
- Memory layout per stage, linear from BASE_ADDR:
  - word0: feature count N (bits [FEAT_W-1:0]);
  - word1: stage threshold (fp32);
  - then N groups of 3 words: left alpha, right alpha, node threshold.
- Read rule: exactly one outstanding read; mem_rd_o pulses 1 cycle; pointer increments on each mem_rdata_val_i.
- mem_rdata_val_i with no read outstanding (IDLE, WAIT_SUM, after reset) is ignored.
- FSM states: IDLE, RD_N, RD_TH, RD_LEFT, RD_RIGHT, RD_NODE, WAIT_SUM, DECIDE, DONE.
  - IDLE: start_i -> RD_N; stage index = 0; pointer = BASE_ADDR. start_i while busy is ignored.
  - RD_N: on data, latch N. new_stage_o pulses in the same cycle the data is captured. -> RD_TH.
  - RD_TH: latch stage threshold. If N==0 -> DECIDE using stage sum = +0.0; else -> RD_LEFT.
  - RD_LEFT / RD_RIGHT / RD_NODE: the cycle after each data return, present the word on thresholds_o with type 01 / 10 / 00 respectively and thresholds_val_o=1 for 1 cycle. thresholds_o holds its last value otherwise.
  - After the node threshold -> WAIT_SUM.
  - WAIT_SUM: on stage_sum_val_i, latch stage_sum_i and increment the feature counter. If count==N -> DECIDE, else -> RD_LEFT.
  - stage_sum_val_i outside WAIT_SUM is ignored.
  - DECIDE (1 cycle): pass_stage = (sum >= stage threshold) in IEEE-754 single.
    - Ordering rule: sign-magnitude ordering, -0 == +0; NaN inputs are not supported.
    - If not pass_stage -> DONE with pass=0, result_stage = stage index.
    - If pass_stage and stage==STAGE_CNT-1 -> DONE with pass=1.
    - Otherwise stage++ -> RD_N.
  - DONE: result_val_o=1 for 1 cycle, result_pass_o/result_stage_o valid with it and held until next start. busy_o drops in the same cycle. -> IDLE.
- Strict per-feature serialization: the next feature's alphas are never issued before the previous feature's stage_sum_val_i. This guarantees the accumulator's alpha registers are stable during its compare.
- Feature counter resets at every new stage. N up to 2^FEAT_W-1.
- Reset mid-operation returns to IDLE next cycle. No result_val_o is produced for the aborted window.

Test Plan:
- 1 stage, N=1, words {1, 0x3F000000 (0.5), 0x3F800000, 0xBF800000, 0x40000000}; stage_sum_i=0x3F800000 (1.0) -> thresholds emitted in type order 01,10,00 with those values; result_val_o with pass=1, stage=0.
- Same but stage_sum_i=0xBF800000 (-1.0) -> pass=0, result_stage_o=0; exactly one new_stage_o pulse.
- STAGE_CNT=3; stage1 rejects (sum 0.25 vs threshold 0.3) -> stage2 header is never read; result_stage_o=1; 2 new_stage_o pulses total.
- Stage with N=0, threshold 0x80000000 (-0.0) -> passes (+0 >= -0), no thresholds_val_o pulses for that stage.
- Memory latency varied 1..7 cycles randomly, plus a spurious stage_sum_val_i during RD_LEFT -> identical emitted word sequence and result to the fixed-latency run; the spurious pulse is not counted.
- rst_i asserted during WAIT_SUM of stage 2 -> all outputs 0 next cycle, no result_val_o. A new start_i rereads from BASE_ADDR.
